// File: rtl/sbtm_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational SBTM datapath between NREQ requesters.
// Optional macro SBTM_ARB_MCP_EN adds EXEC2 so the datapath is timed as a 2-cycle multicycle path.

// Stand-in combinational datapath: rounded Q0.16 square of X.
module datapath (
  input  logic [15:0] X,
  output logic [15:0] answer
);
  logic [31:0] prod;
  assign prod   = (32'(X) * 32'(X)) + 32'h0000_8000;
  assign answer = prod[31:16];
endmodule

module sbtm_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [16*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
  input  logic              rsp_ready,
  output logic              busy
);

`ifdef SBTM_ARB_MCP_EN
  typedef enum logic [1:0] {IDLE, EXEC, EXEC2, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt, win, id_q;
  logic [15:0]    x_q, answer;
  logic           found, cap;
  int             idx;

  datapath u_dp (.X(x_q), .answer(answer));

  // First set bit at or after ptr, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && found) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (found) state_nxt = EXEC;
`ifdef SBTM_ARB_MCP_EN
      EXEC:  state_nxt = EXEC2;
      EXEC2: state_nxt = RESP;
`else
      EXEC:  state_nxt = RESP;
`endif
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SBTM_ARB_MCP_EN
  assign cap = (state == EXEC2);
`else
  assign cap = (state == EXEC);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      x_q      <= '0;
      id_q     <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        x_q  <= req_x[16*int'(win) +: 16];
        id_q <= win;
        ptr  <= ptr_nxt;
      end
      if (cap) begin
        rsp_data <= answer;
        rsp_id   <= id_q;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sbtm_arbiter.sv
// Directed bench for sbtm_arbiter (NREQ=4): grant order, latency, backpressure, reset, operand sweep.
module tb_sbtm_arbiter;
`ifdef SBTM_ARB_MCP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] xv [4];
  int tests = 0;
  int fails = 0;

  assign req_x = {xv[3], xv[2], xv[1], xv[0]};

  sbtm_arbiter #(.NREQ(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] sq(input logic [15:0] x);
    int unsigned p;
    p = int'(x) * int'(x) + 32768;
    return 16'(p >> 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full operation: grant, latency, response fields, optional stall, handshake.
  task automatic run_op(input string tag, input logic [3:0] vmask, input int w,
                        input logic [15:0] expd, input int hold);
    logic [3:0] oh;
    int n;
    oh = 4'(1 << w);
    req_valid = vmask;
    #1;
    chk({tag, ":grant"}, 32'(req_ready), 32'(oh));
    step();
    n = 1;
    chk({tag, ":busy_exec"}, 32'(busy), 32'd1);
    chk({tag, ":ready_exec"}, 32'(req_ready), 32'd0);
    while (!rsp_valid && n < 12) begin
      step();
      n++;
    end
    chk({tag, ":latency"}, 32'(n), 32'(LAT));
    chk({tag, ":rsp_id"}, 32'(rsp_id), 32'(w));
    chk({tag, ":rsp_data"}, 32'(rsp_data), 32'(expd));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":hold_data"}, 32'(rsp_data), 32'(expd));
      chk({tag, ":hold_id"}, 32'(rsp_id), 32'(w));
      chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ":idle_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) xv[i] = 16'h0;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    req_valid = 4'h0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    step();

    // Single request from requester 2 leaves ptr at 3.
    xv[2] = 16'h3A5C;
    run_op("single", 4'b0100, 2, sq(16'h3A5C), 0);
    // Wrap and skip: ptr=3, only requester 1 valid.
    xv[1] = 16'h1234;
    run_op("skip", 4'b0010, 1, sq(16'h1234), 0);
    // ptr must now be 2.
    xv[0] = 16'hAAAA; xv[3] = 16'h5555;
    run_op("ptr2", 4'b1111, 2, sq(16'h3A5C), 0);
    // Backpressure on requester 3's response.
    run_op("bp", 4'b1111, 3, sq(16'h5555), 5);

    // Reset in the EXEC cycle of requester 0's operation.
    req_valid = 4'hF;
    #1;
    chk("rmid_grant", 32'(req_ready), 32'b0001);
    step();
    chk("rmid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rmid_ready_rst", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    req_valid = 4'h0;
    #1;
    chk("rmid_valid", 32'(rsp_valid), 32'd0);
    chk("rmid_busy0", 32'(busy), 32'd0);
    chk("rmid_data", 32'(rsp_data), 32'd0);
    chk("rmid_id", 32'(rsp_id), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rmid_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Fairness after reset: grants 0,1,2,3,0,1.
    xv[0] = 16'h1111; xv[1] = 16'h2222; xv[2] = 16'h3333; xv[3] = 16'h4444;
    run_op("rr0", 4'hF, 0, sq(16'h1111), 0);
    run_op("rr1", 4'hF, 1, sq(16'h2222), 0);
    run_op("rr2", 4'hF, 2, sq(16'h3333), 0);
    run_op("rr3", 4'hF, 3, sq(16'h4444), 0);
    run_op("rr4", 4'hF, 0, sq(16'h1111), 0);
    run_op("rr5", 4'hF, 1, sq(16'h2222), 0);

    // Operand sweep through requester 1, hand-computed results.
    xv[1] = 16'h0000; run_op("sw0000", 4'b0010, 1, 16'h0000, 0);
    xv[1] = 16'hFFFF; run_op("swFFFF", 4'b0010, 1, 16'hFFFE, 0);
    xv[1] = 16'h8000; run_op("sw8000", 4'b0010, 1, 16'h4000, 0);
    xv[1] = 16'h00FF; run_op("sw00FF", 4'b0010, 1, 16'h0001, 0);
    req_valid = 4'h0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
